e_mdu_ctrl: RTL
===============

# e_mdu_ctrl

Execute-stage multiply/divide sequencer for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU (and HI/LO moves) from the E stage and holds the HI/LO architectural registers. It models the fixed multi-cycle latency of the multiplier and divider with a countdown, and exposes a Busy flag that the hazard unit uses to stall D-stage instructions that touch HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for multiply-class ops (≥1)
- DIV_CYCLES, 10, busy cycles for divide-class ops (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Start  input  1  E-stage strobe; launches the op on MDUOp when it is a multiply/divide class op
- MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU (9–12 only with macro)
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Busy  output  1  registered; high while an op is in flight
- HI  output  32  HI register
- LO  output  32  LO register
- MDUout  output  32  HI for MFHI, LO for MFLO, else 0 (combinational from registers)

## Operation
- States: IDLE (cnt==0), RUN (cnt!=0); Busy = (cnt != 0).
- IDLE with Start and a launch op: latch the operands and compute the result into the pending registers pHI/pLO.
  - MULT: signed 64-bit product {pHI,pLO} = A*B. MULTU: unsigned product.
  - DIV: pLO = A/B, pHI = A%B, both signed, truncating toward zero, remainder takes the sign of A. DIVU: unsigned.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN.
- RUN: decrement cnt each cycle. On the edge where cnt goes 1→0, HI<=pHI and LO<=pLO, and return to IDLE.
- Divide by zero (B==0): the op still runs DIV_CYCLES and Busy behaves normally; HI and LO keep their prior values.
- MTHI/MTLO with Start in IDLE: HI<=A or LO<=A at that edge, with no busy period.
- MFHI/MFLO: pure read through MDUout, no state change.
- Start during RUN (any op) is ignored. The hazard unit guarantees this does not happen; the guard is a backstop.
- MDUOp NONE or Start=0: no effect.
- Reset (asynchronous, any time, including mid-RUN): cnt=0, Busy=0, HI=0, LO=0, pHI=pLO=0. The in-flight op is discarded.

## Timing
- Launch edge = the edge that samples Start=1. Busy is 1 for exactly N cycles after it, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO update on the edge at which Busy falls. MDUout reflects the new values in the following cycle, so an MFHI issued in the cycle after Busy=0 reads the result.
- MTHI/MTLO: HI/LO visible in the cycle after the launch edge.
- Stall rule for the hazard unit: stall the D-stage HI/LO instruction when Busy | (Start & launch op in E). This module does not generate the stall itself.
- Back-to-back: a new launch op is accepted on the first edge at which Busy=0.

## Configuration
- Macro: MDU_MADD_EN.
- Defined: ops 9–12 are launch ops with a MULT_CYCLES latency.
  - MADD: {HI,LO} + signed A*B. MADDU: {HI,LO} + unsigned A*B. MSUB/MSUBU: subtract instead of add.
  - Arithmetic is 64-bit modulo 2^64, using HI/LO sampled at the launch edge.
- Undefined: ops 9–12 are treated as NONE (no Busy, no state change).

## Test plan
- Reset deasserted, Start MULT A=0xFFFFFFFE, B=3 → Busy high 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Start DIVU A=7, B=2 → Busy high 10 cycles. Then LO=3, HI=1. Signed DIV A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678, next cycle MFHI → MDUout=0x12345678, Busy never asserted. DIV with B=0 after that → HI stays 0x12345678.
- Start MULT, then Start DIV asserted at cycle 2 of RUN → DIV ignored. MULT result lands at cycle 5, Busy drops, and DIV is accepted only when relaunched.
- Assert reset at cycle 3 of a DIV → Busy, HI, LO all 0 immediately (asynchronous). After release, no stale write occurs.
- With MDU_MADD_EN defined: HI:LO=0:5, MADD A=2, B=3 → after 5 cycles LO=11, HI=0. MSUBU A=1, B=12 → HI=0xFFFFFFFF, LO=0xFFFFFFFF. Without the macro, the same ops leave HI/LO unchanged and Busy=0.

Source files
------------

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl -- execute-stage multiply/divide sequencer.
//
// This block holds the HI/LO architectural registers. It models the fixed
// latency of the multiplier and divider with a down-counter. The result is
// computed at the launch edge and parked in pHI/pLO. It is committed to HI/LO
// on the edge where the counter reaches zero.
//
// Parameters:
//   MULT_CYCLES : busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES  : busy cycles for divide-class ops   (>= 1)
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-low reset
//   Start  in   1  E-stage strobe; launches MDUOp when it is a launch op
//   MDUOp  in   4  0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,
//                  7 MTHI,8 MTLO,9 MADD,10 MADDU,11 MSUB,12 MSUBU
//   A      in  32  rs operand
//   B      in  32  rt operand
//   Busy   out  1  registered, high while an op is in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
//   MDUout out 32  HI for MFHI, LO for MFLO, else 0
//
// Optional feature macro: MDU_MADD_EN.
//   When it is defined, ops 9-12 (MADD/MADDU/MSUB/MSUBU) accumulate into
//   {HI,LO} with the multiply latency.
//   When it is not defined, ops 9-12 behave as NONE.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [CNT_W-1:0] C_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_CYCLES);

  // State: the counter is the FSM (IDLE when zero, RUN otherwise).
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi, r_lo, r_phi, r_plo;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_hi_nxt, w_lo_nxt, w_phi_nxt, w_plo_nxt;

  // Arithmetic datapath, evaluated on the live operands.
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_b_zero;
  logic        [31:0] w_dvs;
  logic signed [31:0] w_q_s, w_r_s;
  logic        [31:0] w_q_u, w_r_u;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_b_zero = (B == 32'd0);
  // A zero divisor is replaced by 1 so that the divider never produces X.
  // The result is discarded in that case anyway.
  assign w_dvs    = w_b_zero ? 32'd1 : B;
  assign w_q_s    = $signed(A) / $signed(w_dvs);
  assign w_r_s    = $signed(A) % $signed(w_dvs);
  assign w_q_u    = A / w_dvs;
  assign w_r_u    = A % w_dvs;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_phi  <= '0;
      r_plo  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_phi  <= w_phi_nxt;
      r_plo  <= w_plo_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    w_phi_nxt = r_phi;
    w_plo_nxt = r_plo;
    if (r_cnt != '0) begin
      // RUN: Start is ignored here. The last countdown edge commits the result.
      w_cnt_nxt = r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        w_hi_nxt = r_phi;
        w_lo_nxt = r_plo;
      end
    end else if (Start) begin
      case (MDUOp)
        OP_MULT: begin
          {w_phi_nxt, w_plo_nxt} = w_prod_s;
          w_cnt_nxt = C_MULT;
        end
        OP_MULTU: begin
          {w_phi_nxt, w_plo_nxt} = w_prod_u;
          w_cnt_nxt = C_MULT;
        end
        OP_DIV: begin
          // For divide by zero, the pending value is the current HI/LO.
          // The commit at the end is then a no-op.
          w_phi_nxt = w_b_zero ? r_hi : w_r_s;
          w_plo_nxt = w_b_zero ? r_lo : w_q_s;
          w_cnt_nxt = C_DIV;
        end
        OP_DIVU: begin
          w_phi_nxt = w_b_zero ? r_hi : w_r_u;
          w_plo_nxt = w_b_zero ? r_lo : w_q_u;
          w_cnt_nxt = C_DIV;
        end
        OP_MTHI: w_hi_nxt = A;
        OP_MTLO: w_lo_nxt = A;
`ifdef MDU_MADD_EN
        OP_MADD: begin
          {w_phi_nxt, w_plo_nxt} = w_acc + w_prod_s;
          w_cnt_nxt = C_MULT;
        end
        OP_MADDU: begin
          {w_phi_nxt, w_plo_nxt} = w_acc + w_prod_u;
          w_cnt_nxt = C_MULT;
        end
        OP_MSUB: begin
          {w_phi_nxt, w_plo_nxt} = w_acc - w_prod_s;
          w_cnt_nxt = C_MULT;
        end
        OP_MSUBU: begin
          {w_phi_nxt, w_plo_nxt} = w_acc - w_prod_u;
          w_cnt_nxt = C_MULT;
        end
`endif
        default: ;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    MDUout = 32'd0;
    case (MDUOp)
      OP_MFHI: MDUout = r_hi;
      OP_MFLO: MDUout = r_lo;
      default: ;
    endcase
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
